// File: rtl/vsum_pkg.sv
// -----------------------------------------------------------------------------
// vsum_pkg
// Shared definitions for the vector-sum accumulator slice.
//   LANES_D, WIDTH_D, CNT_W_D : default lane count, lane width, beat-counter width
//   acc_w_f()                 : accumulator width that cannot overflow for a
//                               maximum-length job of worst-case lanes
//   vsum_state_t              : accumulator FSM states
// -----------------------------------------------------------------------------
package vsum_pkg;

   localparam int LANES_D = 4;
   localparam int WIDTH_D = 8;
   localparam int CNT_W_D = 8;

   // Lane width, plus growth from summing the lanes of one beat,
   // plus growth from summing up to 2**cnt_w - 1 beats.
   function automatic int acc_w_f(input int lanes, input int width, input int cnt_w);
      return width + $clog2(lanes) + cnt_w;
   endfunction

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } vsum_state_t;

endpackage

// File: rtl/vsum_acc_lane_sum.sv
// -----------------------------------------------------------------------------
// vlane_sum
// Combinational reduction of one vector beat to a single signed sum.
// Each lane is sign-extended to the full output width before adding, so the
// sum is exact for any lane values.
//   data_i : LANES*WIDTH packed lanes, lane i at [i*WIDTH +: WIDTH], two's complement
//   sum_o  : ACC_W-bit signed sum of all lanes
// -----------------------------------------------------------------------------
module vlane_sum
   import vsum_pkg::*;
#(
   parameter int LANES = LANES_D,
   parameter int WIDTH = WIDTH_D,
   parameter int ACC_W = acc_w_f(LANES_D, WIDTH_D, CNT_W_D)
) (
   input  logic        [LANES*WIDTH-1:0] data_i,
   output logic signed [ACC_W-1:0]       sum_o
);

   logic signed [WIDTH-1:0] lane;
   logic signed [ACC_W-1:0] sum;

   always_comb begin
      lane = '0;
      sum  = '0;
      for (int i = 0; i < LANES; i++) begin
         lane = data_i[i*WIDTH +: WIDTH];
         // Size cast of a signed operand sign-extends it.
         sum  = sum + ACC_W'(lane);
      end
   end

   assign sum_o = sum;

endmodule

// File: rtl/vsum_acc.sv
// -----------------------------------------------------------------------------
// vsum_acc
// Accumulates a programmed number of vector beats into one signed result.
// A job starts with a start pulse (len beats, len may be 0), consumes beats
// over a valid/ready input, and presents the full-precision sum on a
// valid/ready output. Throughput is one beat per cycle; the result appears
// the cycle after the last beat is accepted.
//   clock     : rising-edge clock
//   reset     : synchronous, active-high; abandons any job in flight
//   start     : job start pulse, honoured only in IDLE
//   len       : beats in the job, sampled with start
//   in_valid  : upstream beat valid
//   in_ready  : beat accepted this cycle when in_valid is also high
//   in_data   : LANES packed signed lanes
//   out_valid : result valid, held until out_ready
//   out_ready : downstream accepts the result
//   result    : signed accumulated sum
//   busy      : job in progress (ACC or DONE)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module vsum_acc
   import vsum_pkg::*;
#(
   parameter int LANES = LANES_D,
   parameter int WIDTH = WIDTH_D,
   parameter int CNT_W = CNT_W_D,
   parameter int ACC_W = acc_w_f(LANES, WIDTH, CNT_W)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [CNT_W-1:0]         len,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*WIDTH-1:0]   in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [ACC_W-1:0]  result,
   output logic                     busy
);

   vsum_state_t             state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] result_q;
   logic                    in_ready_q;
   logic                    out_valid_q;
   logic                    busy_q;
   logic signed [ACC_W-1:0] beat_sum;
   logic                    beat_accept;
   logic                    out_accept;

   vlane_sum #(
      .LANES (LANES),
      .WIDTH (WIDTH),
      .ACC_W (ACC_W)
   ) u_lane_sum (
      .data_i (in_data),
      .sum_o  (beat_sum)
   );

   // in_ready_q / out_valid_q are exactly "in ACC" / "in DONE", so the
   // handshakes can be qualified with the registered copies.
   assign beat_accept = in_valid && in_ready_q;
   assign out_accept  = out_valid_q && out_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               acc_d = '0;
               if (len != '0) begin
                  cnt_d   = len;
                  state_d = ACC;
               end else begin
                  // Empty job: go straight to DONE with a zero result.
                  state_d = DONE;
               end
            end
         end
         ACC: begin
            if (beat_accept) begin
               acc_d = acc_q + beat_sum;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            // A start arriving with out_ready here is deliberately dropped.
            if (out_accept) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         result_q    <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         in_ready_q  <= (state_d == ACC);
         out_valid_q <= (state_d == DONE);
         busy_q      <= (state_d != IDLE);
         // acc does not move in DONE, so result stays stable during a stall.
         if (state_d == DONE) begin
            result_q <= acc_d;
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign result    = result_q;

endmodule

// File: tb/tb_vsum_acc.sv
module tb_vsum_acc;

   localparam int LANES = 4;
   localparam int WIDTH = 8;
   localparam int CNT_W = 8;
   localparam int ACC_W = 18;

   logic                     clock;
   logic                     reset;
   logic                     start;
   logic [CNT_W-1:0]         len;
   logic                     in_valid;
   logic                     in_ready;
   logic [LANES*WIDTH-1:0]   in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [ACC_W-1:0]  result;
   logic                     busy;

   vsum_acc #(
      .LANES (LANES),
      .WIDTH (WIDTH),
      .CNT_W (CNT_W),
      .ACC_W (ACC_W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_vec  = 0;
   int n_miss = 0;
   logic signed [ACC_W-1:0] exp_q[$];

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Scoreboard monitor: one handshake per DONE cycle with out_ready high.
   initial begin
      logic signed [ACC_W-1:0] e;
      forever begin
         @(negedge clock);
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL unexpected result: got %0d, expected no output", result);
            end else begin
               e = exp_q.pop_front();
               check("result", $signed(result), e);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic run_job(input int n, input logic [31:0] data,
                          input logic signed [ACC_W-1:0] expv, input string name);
      int acc_n = 0;
      int guard = 0;
      exp_q.push_back(expv);
      start = 1'b1;
      len   = CNT_W'(n);
      step();
      start    = 1'b0;
      in_data  = data;
      in_valid = (n != 0);
      while (acc_n < n && guard < 2000) begin
         if (in_ready) acc_n++;
         step();
         guard++;
      end
      in_valid = 1'b0;
      check({name, " beats accepted"}, acc_n, n);
      check({name, " out_valid after last beat"}, out_valid, 1);
      check({name, " in_ready low in DONE"}, in_ready, 0);
      guard = 0;
      while (busy && guard < 100) begin
         step();
         guard++;
      end
      check({name, " returned to idle"}, busy, 0);
   endtask

   initial begin
      int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
      int acc_n;

      reset     = 1'b1;
      start     = 1'b0;
      len       = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      check("reset out_valid", out_valid, 0);
      check("reset in_ready", in_ready, 0);
      check("reset busy", busy, 0);
      check("reset result", $signed(result), 0);

      // Basic accumulate: lanes {2,6,16,11} x3
      run_job(3, {8'd11, 8'd16, 8'd6, 8'd2}, 18'sd105, "basic");

      // Signed extremes
      run_job(255, 32'h80808080, -18'sd130560, "min");
      run_job(255, 32'h7F7F7F7F, 18'sd129540, "max");

      // Upstream and downstream stalls
      out_ready = 1'b0;
      exp_q.push_back(18'sd16);
      start = 1'b1;
      len   = 8'd4;
      step();
      start   = 1'b0;
      in_data = 32'h01010101;
      acc_n   = 0;
      for (int i = 0; i < 7; i++) begin
         in_valid = pat[i][0];
         if (in_valid && in_ready) acc_n++;
         step();
      end
      in_valid = 1'b0;
      check("stall beats accepted", acc_n, 4);
      for (int i = 0; i < 5; i++) begin
         check("stall out_valid held", out_valid, 1);
         check("stall result stable", $signed(result), 16);
         step();
      end
      out_ready = 1'b1;
      step();
      check("stall idle after accept", busy, 0);
      check("stall out_valid dropped", out_valid, 0);

      // Empty job
      run_job(0, 32'h0, 18'sd0, "empty");

      // Start during ACC is ignored; start with out_ready in DONE is ignored
      exp_q.push_back(18'sd6);
      start = 1'b1;
      len   = 8'd2;
      step();
      in_data  = 32'h00000003;
      in_valid = 1'b1;
      start    = 1'b1;
      len      = 8'd7;
      step();
      start = 1'b0;
      step();
      in_valid = 1'b0;
      check("extra start out_valid", out_valid, 1);
      start = 1'b1;
      len   = 8'd1;
      step();
      start = 1'b0;
      check("start in DONE ignored", busy, 0);
      step();
      check("no queued job", busy, 0);

      // Reset mid-job
      start = 1'b1;
      len   = 8'd5;
      step();
      start    = 1'b0;
      in_data  = 32'h05050505;
      in_valid = 1'b1;
      step();
      step();
      in_valid = 1'b0;
      reset    = 1'b1;
      step();
      reset = 1'b0;
      check("midreset out_valid", out_valid, 0);
      check("midreset in_ready", in_ready, 0);
      check("midreset busy", busy, 0);
      check("midreset result", $signed(result), 0);
      step();
      check("midreset job abandoned", busy, 0);
      run_job(1, 32'hFFFFFFFF, -18'sd4, "after reset");

      // Back-to-back jobs
      run_job(1, 32'h0A0A0A0A, 18'sd40, "job A");
      run_job(1, 32'h000000FB, -18'sd5, "job B");

      step();
      check("scoreboard drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
